sram_1w1r_fifo_ctrl: RTL
========================

Name: sram_1w1r_fifo_ctrl

Overview:
- Single-clock FIFO controller that sits directly in front of and behind a freepdk45 1w1r SRAM macro, default 12x256.
- Turns a valid/ready push stream into port-0 writes.
- Issues port-1 reads and captures dout1 into a 2-entry output buffer, presenting a first-word-fall-through valid/ready pop stream.
- Owns all pointer, full/empty and SRAM timing-hazard logic, so clients never drive macro pins directly.

Parameters:
- DATA_WIDTH, 12, SRAM word width; must match the macro.
- ADDR_WIDTH, 8, SRAM address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, SRAM entries; derived, not overridden.
- OBUF_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk0  in  1  single clock; also wired to both macro clk0 and clk1.
- rstb0  in  1  asynchronous active-low reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  push data.
- out_valid  out  1  head of FIFO available.
- out_ready  in  1  pop when out_valid && out_ready.
- out_data  out  DATA_WIDTH  head data.
- level  out  ADDR_WIDTH+2  total entries held (SRAM + in-flight + obuf).
- sram_csb0  out  1  macro write chip select, active low.
- sram_addr0  out  ADDR_WIDTH  macro write address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_csb1  out  1  macro read chip select, active low.
- sram_addr1  out  ADDR_WIDTH  macro read address.
- sram_dout1  in  DATA_WIDTH  macro read data.

Behaviour:
- Macro timing contract:
  - Pins are sampled at posedge; the write lands at the following negedge.
  - Read data is valid after that negedge and goes X shortly after the next posedge.
  - The controller therefore drives macro pins combinationally in cycle N and captures sram_dout1 exactly at the posedge ending cycle N+1.
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits.
  - sram_cnt = wr_ptr - rd_ptr (modulo).
  - sram_full when MSBs differ and low bits are equal.
  - sram_empty when pointers are equal.
  - Low bits wrap 255->0; the MSB toggles on each wrap.
- Push:
  - in_ready = !sram_full, registered-state only; a same-cycle read does not free space.
  - On accept: sram_csb0=0, sram_addr0=wr_ptr[ADDR_WIDTH-1:0], sram_din0=in_data; wr_ptr increments at the posedge.
  - Otherwise sram_csb0=1.
- Read issue:
  - Issue when !sram_empty && (obuf_cnt + inflight - pop) < 2, where pop = out_valid && out_ready.
  - On issue: sram_csb1=0, sram_addr1=rd_ptr low bits; rd_ptr increments; inflight<=1.
  - Otherwise sram_csb1=1 and inflight<=0.
  - Only slots whose write was sampled on an earlier edge are readable, so same-address read/write in one cycle cannot occur; this is a checked invariant.
- Capture: when inflight=1, sram_dout1 is written into the obuf at that posedge.
- Output:
  - out_valid = obuf_cnt != 0; out_data = obuf head.
  - Pop and capture in the same cycle are both honoured.
  - Sustained throughput is 1 word/cycle.
- Latency: push accepted in cycle N gives out_valid in cycle N+3 at the earliest (FIFO empty, no bypass).
- level = sram_cnt + inflight + obuf_cnt; maximum RAM_DEPTH+2.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - Pointers 0; inflight 0; obuf_cnt 0.
  - out_valid 0; out_data 0; level 0; in_ready 1 after release.
  - sram_csb0=sram_csb1=1 while rstb0=0.
  - Reset mid-operation drops in-flight read data and all contents; SRAM array is not cleared.
- Boundaries:
  - Full with push and pop in the same cycle: push is refused.
  - Empty with a push: no read is issued that cycle.
  - out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro SRAM_FIFO_BYPASS_EN.
- When defined: if sram_empty && inflight=0 && obuf has room, an accepted push writes in_data straight into the obuf and no SRAM write occurs. out_valid then rises in cycle N+1.
- Ordering is preserved because bypass requires the SRAM and in-flight path to be empty.
- When undefined: every word goes through the SRAM; latency is N+3.

Decomposition:
- Package sram_fifo_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - RAM_DEPTH.
  - OBUF_DEPTH.
  - Pointer and level width constants.
- Sub-module sram_fifo_obuf: 2-entry register FIFO with push (capture/bypass), pop, count and head data.
- Top level holds the pointers, read-issue credit logic and macro pin drive.

Test Plan:
- Reset then single push 0xABC in cycle 0, out_ready=1 -> sram_csb0=0 with addr0=0 in cycle 0; sram_csb1=0 with addr1=0 in cycle 1; out_valid=1, out_data=0xABC in cycle 3; level returns to 0.
- 256 pushes with out_ready=0 -> level=256 in SRAM, then obuf fills to level 258; in_ready=0 at sram_full; push #259 is refused and data is unchanged.
- Continuous push and pop of ramp 0..1023 with out_ready=1 -> in-order output, 1 word/cycle after fill, pointers wrap 255->0 four times, no sram_csb1=0 with addr1==addr0 while sram_csb0=0.
- Random out_ready (50%) with random in_valid, 10k words -> scoreboard order exact; level matches model every cycle; no X on out_data when out_valid=1.
- Assert rstb0=0 mid-stream with inflight=1 -> out_valid=0, level=0, sram_csb0/csb1=1 immediately; after release a push of 0x123 emerges first.
- SRAM_FIFO_BYPASS_EN defined, empty FIFO, push 0x5A5 in cycle 0 -> out_valid in cycle 1, sram_csb0 stays 1.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed FIFO controller and its output buffer.
package sram_fifo_pkg;

  // Default geometry of the freepdk45 1w1r 12x256 macro.
  localparam int DATA_WIDTH_DEF = 12;
  localparam int ADDR_WIDTH_DEF = 8;

  // Output buffer depth is fixed; the read-credit logic assumes exactly two slots.
  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CNT_W = 2;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Level covers the SRAM contents plus the in-flight read plus the buffer.
  function automatic int level_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry register FIFO that holds words read back from the SRAM (or
// bypassed pushes) and presents the head word first-word-fall-through.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OBUF_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [OBUF_CNT_W-1:0] cnt;
  logic                  pop_ok;

  // A pop with nothing held is ignored rather than corrupting the count.
  assign pop_ok    = pop && (cnt != '0);
  assign count     = cnt;
  assign head_data = mem[rd_idx];

  // Storage, ring indices and occupancy count.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      // NOTE: these two slots are plain flops, so resetting them is cheap and
      // makes out_data read 0 out of reset; the SRAM array itself is never cleared.
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop_ok) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + OBUF_CNT_W'(1);
        2'b01:   cnt <= cnt - OBUF_CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_1w1r_fifo_ctrl.sv
// FIFO controller in front of a 1w1r SRAM macro: push stream -> port-0
// writes, port-1 reads -> 2-entry output buffer -> FWFT pop stream.
// Optional macro SRAM_FIFO_BYPASS_EN: when the SRAM and read path are empty,
// pushes go straight into the output buffer (out_valid one cycle later).
module sram_1w1r_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W     = ptr_width(ADDR_WIDTH);
  localparam int LVL_W     = level_width(ADDR_WIDTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      sram_cnt;
  logic                  sram_full;
  logic                  sram_empty;
  logic                  inflight;
  logic [OBUF_CNT_W-1:0] obuf_cnt;
  logic [2:0]            credit_next;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  wr_sram;
  logic                  rd_issue;
  logic                  obuf_push;
  logic [DATA_WIDTH-1:0] obuf_din;

  // Occupancy of the SRAM from the wrap-bit pointers.
  assign sram_cnt   = wr_ptr - rd_ptr;
  assign sram_empty = (wr_ptr == rd_ptr);
  assign sram_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // Space is judged on registered state only; a same-cycle read frees nothing.
  assign in_ready  = !sram_full;
  assign push_fire = in_valid && in_ready;
  assign out_valid = (obuf_cnt != '0);
  assign pop_fire  = out_valid && out_ready;

  // Buffer occupancy once this cycle's capture and pop have landed; a read
  // issued now lands one cycle after that, so it needs this to be below 2.
  assign credit_next = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop_fire};

  // An empty SRAM has no slot whose write was sampled on an earlier edge, so
  // the read address can never equal the address being written this cycle.
  assign rd_issue = !sram_empty && (credit_next < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
  logic bypass_ok;

  // Bypass only when nothing older is in the SRAM or on the read path.
  assign bypass_ok = sram_empty && !inflight && (obuf_cnt < OBUF_CNT_W'(OBUF_DEPTH));
  assign wr_sram   = push_fire && !bypass_ok;
  assign obuf_push = inflight || (push_fire && bypass_ok);
  assign obuf_din  = inflight ? sram_dout1 : in_data;
`else
  assign wr_sram   = push_fire;
  assign obuf_push = inflight;
  assign obuf_din  = sram_dout1;
`endif

  // Macro pin drive; chip selects are forced inactive while reset is low.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned and infers a latch.
    sram_csb0  = 1'b1;
    sram_addr0 = wr_ptr[ADDR_WIDTH-1:0];
    sram_din0  = in_data;
    sram_csb1  = 1'b1;
    sram_addr1 = rd_ptr[ADDR_WIDTH-1:0];
    if (rstb0 && wr_sram) begin
      sram_csb0 = 1'b0;
    end
    if (rstb0 && rd_issue) begin
      sram_csb1 = 1'b0;
    end
  end

  // Pointers and the one-deep read-in-flight marker.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_sram) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      inflight <= rd_issue;
    end
  end

  // Read data is valid only through the posedge that ends the cycle after
  // issue, so capture happens exactly when inflight is set.
  sram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk0      (clk0),
    .rstb0     (rstb0),
    .push      (obuf_push),
    .push_data (obuf_din),
    .pop       (pop_fire),
    .count     (obuf_cnt),
    .head_data (out_data)
  );

  assign level = LVL_W'(sram_cnt) + LVL_W'(inflight) + LVL_W'(obuf_cnt);

endmodule
